snake_core_ring: RTL and testbench
==================================

Name: snake_core_ring

Overview:
- Parametrised snake game engine for the VGA snake design; successor to the fixed 80x60, shift-array game logic.
- Body held in a ring buffer of cell coordinates, plus a COLS*ROWS occupancy bitmap, so collision checks and per-pixel lookups are single reads.
- Advances one move per `step` pulse from the frame timer.
- Exposes a registered cell-query port for the pixel renderer, plus score/length/dead status for the HEX displays.

Parameters:
- COLS, 80, grid width in cells.
- ROWS, 60, grid height in cells.
- BODY_MAX, 64, ring depth and maximum snake length; must be ≥2 and < COLS*ROWS.
- SCORE_W, 8, score counter width.
- Derived: XW = $clog2(COLS), YW = $clog2(ROWS), LW = $clog2(BODY_MAX+1).

Ports:
- clk  in  1  system clock (VGA_CLK domain).
- reset  in  1  synchronous, active-high; restarts the game.
- step  in  1  one-cycle pulse; request one move.
- dir_valid  in  1  dir_in valid this cycle.
- dir_in  in  2  0=+x, 1=+y, 2=-x, 3=-y.
- rnd  in  16  free-running LFSR value; [15:8]=x candidate, [7:0]=y candidate.
- query_x  in  XW  renderer cell column.
- query_y  in  YW  renderer cell row.
- query_body  out  1  queried cell is occupied; 1-cycle latency.
- query_food  out  1  queried cell is food; 1-cycle latency.
- head_x  out  XW  current head column.
- head_y  out  YW  current head row.
- food_x  out  XW  current food column.
- food_y  out  YW  current food row.
- length  out  LW  current body length, head included.
- score  out  SCORE_W  foods eaten, saturating.
- dead  out  1  game over; sticky until reset.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (sync, dominates all other inputs):
  - bitmap cleared except the head cell; ring holds one entry; head = (COLS/2, ROWS/2); length = 1.
  - score = 0, dead = 0, committed dir = 0, pending dir = 0.
  - food = (0,0); query outputs 0.
  - FSM enters FOOD, so busy = 1 on the first cycle after reset.
- Direction handling:
  - dir_valid loads pending_dir on any cycle.
  - The load is rejected if length > 1 and dir_in == committed_dir ^ 2'b10 (reversal).
  - pending_dir is copied to committed_dir when a step is accepted.
- IDLE:
  - step && !dead accepts a move; nxt = head + committed_dir.
  - Wrap-around: COLS-1 → 0, 0 → COLS-1; same for rows.
  - Go to TAIL.
  - step while busy or dead is ignored; it is not queued.
- TAIL:
  - eat = (nxt == food) && (length < BODY_MAX).
  - If !eat: clear bitmap at ring[tail], then tail_ptr++ mod BODY_MAX.
  - Go to HEAD.
  - Clearing the tail before the check means moving into the just-vacated tail cell is legal.
- HEAD:
  - If bitmap[nxt] is set: dead = 1, head not written, go to IDLE.
  - Otherwise: set bitmap[nxt]; head_ptr++ mod BODY_MAX; ring[head_ptr] = nxt; head = nxt.
  - If eat: length++, score++ (holds at all-ones), go to FOOD; else go to IDLE.
- Food at BODY_MAX length:
  - Eating at length == BODY_MAX moves normally (no growth).
  - score still increments and FOOD is still entered.
- FOOD (one candidate per cycle):
  - cx = rnd[15:8], cy = rnd[7:0].
  - Reject if cx ≥ COLS, cy ≥ ROWS, or bitmap[cx,cy] is set.
  - On accept: food = (cx, cy), go to IDLE.
  - No timeout; BODY_MAX < COLS*ROWS guarantees a free cell exists.
- Move latency: step accepted → IDLE after 3 cycles (no eat) or 3 + N cycles (eat, N candidates tried).
  - head_x/head_y update on the HEAD cycle.
- Query port:
  - query_body / query_food registered one cycle after query_x / query_y.
  - Out-of-range coordinates → 0.
  - Reads the live bitmap; an update in the same cycle is not visible until the next cycle.

Optional Feature:
- SNAKE_WALL_EN defined:
  - In IDLE, a move off any edge sets dead = 1 and returns to IDLE.
  - No bitmap or ring change, no wrap.
- Not defined: edges wrap as described in IDLE.

Test Plan:
- Reset → head = (40,30), length = 1, busy = 1; with rnd = 16'h0A05 → food = (10,5), busy = 0 one cycle after FOOD is entered.
- Reset, food placed away from the row, dir 0, 39 steps → head = (79,30); 1 more step → head = (0,30) (wrap), dead = 0.
- Same with SNAKE_WALL_EN defined → step at (79,30) sets dead = 1; head stays (79,30); further steps ignored.
- Place food at (41,30) via rnd = 16'h291E, dir 0, 1 step → length = 2, score = 1; rnd = 16'hFFFF held for 4 cycles then 16'h0101 → food = (1,1) after 4 rejected tries.
- Grow to length 5, then issue dir 1, 2, 3 with steps (tight loop) → head re-enters its own body, dead = 1, score unchanged; at length 2, dir_in = 2 while heading 0 → pending_dir unchanged.
- query (40,30) after reset → query_body = 1 next cycle; query (80,0) → 0; query at food cell → query_food = 1.

Source files
------------

// File: rtl/snake_core_ring.sv
`default_nettype none
// ============================================================================
//  Module   : snake_core_ring
//  Purpose  : Parametrised snake game engine. The body is kept as a ring
//             buffer of cell coordinates plus a COLS*ROWS occupancy bitmap,
//             so collision checks and renderer lookups are single reads.
//             One move per step pulse; registered cell-query port.
//  Options  : define SNAKE_WALL_EN to make grid edges lethal instead of
//             wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module snake_core_ring #(
    parameter  int COLS     = 80,
    parameter  int ROWS     = 60,
    parameter  int BODY_MAX = 64,
    parameter  int SCORE_W  = 8,
    localparam int XW       = $clog2(COLS),
    localparam int YW       = $clog2(ROWS),
    localparam int LW       = $clog2(BODY_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               dir_valid,
    input  logic [1:0]         dir_in,
    input  logic [15:0]        rnd,
    input  logic [XW-1:0]      query_x,
    input  logic [YW-1:0]      query_y,
    output logic               query_body,
    output logic               query_food,
    output logic [XW-1:0]      head_x,
    output logic [YW-1:0]      head_y,
    output logic [XW-1:0]      food_x,
    output logic [YW-1:0]      food_y,
    output logic [LW-1:0]      length,
    output logic [SCORE_W-1:0] score,
    output logic               dead,
    output logic               busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int IW    = $clog2(CELLS);
    localparam int PW    = $clog2(BODY_MAX);

    localparam logic [XW-1:0] C_XMAX    = XW'(COLS - 1);
    localparam logic [YW-1:0] C_YMAX    = YW'(ROWS - 1);
    localparam logic [XW-1:0] C_HX      = XW'(COLS / 2);
    localparam logic [YW-1:0] C_HY      = YW'(ROWS / 2);
    localparam logic [LW-1:0] C_LEN_MAX = LW'(BODY_MAX);
    localparam logic [IW-1:0] C_START   = IW'((ROWS / 2) * COLS + (COLS / 2));
    localparam logic [PW-1:0] C_PTR_MAX = PW'(BODY_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAIL = 2'd1,
        S_HEAD = 2'd2,
        S_FOOD = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CELLS-1:0]   r_bitmap;
    logic [XW-1:0]      r_ring_x [BODY_MAX];
    logic [YW-1:0]      r_ring_y [BODY_MAX];
    logic [PW-1:0]      r_head_ptr, r_tail_ptr;
    logic [XW-1:0]      r_head_x, r_food_x, r_nxt_x;
    logic [YW-1:0]      r_head_y, r_food_y, r_nxt_y;
    logic [LW-1:0]      r_len;
    logic [SCORE_W-1:0] r_score;
    logic               r_dead;
    logic [1:0]         r_pdir, r_cdir;
    logic               r_qbody, r_qfood;

    logic [XW-1:0]      w_mx;
    logic [YW-1:0]      w_my;
    logic               w_accept, w_wall_die, w_hit, w_grow, w_nxt_occ;
    logic               w_cand_ok, w_q_in;
    logic [7:0]         w_cx, w_cy;
    logic [PW-1:0]      w_head_ptr_nxt;

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        return IW'(y) * IW'(COLS) + IW'(x);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign w_accept       = (r_state == S_IDLE) && step && !r_dead;
    assign w_hit          = (r_nxt_x == r_food_x) && (r_nxt_y == r_food_y);
    assign w_grow         = w_hit && (r_len < C_LEN_MAX);
    assign w_nxt_occ      = r_bitmap[cell_idx(r_nxt_x, r_nxt_y)];
    assign w_head_ptr_nxt = ptr_inc(r_head_ptr);
    assign w_cx           = rnd[15:8];
    assign w_cy           = rnd[7:0];
    assign w_cand_ok      = (32'(w_cx) < COLS) && (32'(w_cy) < ROWS) &&
                            !r_bitmap[cell_idx(XW'(w_cx), YW'(w_cy))];
    assign w_q_in         = (32'(query_x) < COLS) && (32'(query_y) < ROWS);

`ifdef SNAKE_WALL_EN
    assign w_wall_die = ((r_pdir == 2'd0) && (r_head_x == C_XMAX)) ||
                        ((r_pdir == 2'd1) && (r_head_y == C_YMAX)) ||
                        ((r_pdir == 2'd2) && (r_head_x == '0))     ||
                        ((r_pdir == 2'd3) && (r_head_y == '0));
`else
    assign w_wall_die = 1'b0;
`endif

    // Neighbour cell in the direction being committed, wrapping at edges.
    // The move uses pending_dir, i.e. the value that becomes committed.
    always_comb begin
        w_mx = r_head_x;
        w_my = r_head_y;
        case (r_pdir)
            2'd0:    w_mx = (r_head_x == C_XMAX) ? '0 : r_head_x + 1'b1;
            2'd1:    w_my = (r_head_y == C_YMAX) ? '0 : r_head_y + 1'b1;
            2'd2:    w_mx = (r_head_x == '0) ? C_XMAX : r_head_x - 1'b1;
            default: w_my = (r_head_y == '0) ? C_YMAX : r_head_y - 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FOOD;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !w_wall_die) w_state_nxt = S_TAIL;
            S_TAIL: w_state_nxt = S_HEAD;
            S_HEAD: w_state_nxt = (!w_nxt_occ && w_hit) ? S_FOOD : S_IDLE;
            S_FOOD: if (w_cand_ok) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Game datapath: direction, ring/bitmap updates, status and query port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitmap          <= '0;
            r_bitmap[C_START] <= 1'b1;
            r_ring_x[0]       <= C_HX;
            r_ring_y[0]       <= C_HY;
            r_head_ptr        <= '0;
            r_tail_ptr        <= '0;
            r_head_x          <= C_HX;
            r_head_y          <= C_HY;
            r_nxt_x           <= C_HX;
            r_nxt_y           <= C_HY;
            r_food_x          <= '0;
            r_food_y          <= '0;
            r_len             <= LW'(1);
            r_score           <= '0;
            r_dead            <= 1'b0;
            r_pdir            <= 2'd0;
            r_cdir            <= 2'd0;
            r_qbody           <= 1'b0;
            r_qfood           <= 1'b0;
        end else begin
            // A reversal onto the neck is only meaningful once there is a neck.
            if (dir_valid && !((r_len > LW'(1)) && (dir_in == (r_cdir ^ 2'b10))))
                r_pdir <= dir_in;

            r_qbody <= w_q_in && r_bitmap[cell_idx(query_x, query_y)];
            r_qfood <= w_q_in && (query_x == r_food_x) && (query_y == r_food_y);

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cdir  <= r_pdir;
                        r_nxt_x <= w_mx;
                        r_nxt_y <= w_my;
                        if (w_wall_die) r_dead <= 1'b1;
                    end
                end
                S_TAIL: begin
                    // Vacate the tail first so following it closely is legal.
                    if (!w_grow) begin
                        r_bitmap[cell_idx(r_ring_x[r_tail_ptr], r_ring_y[r_tail_ptr])] <= 1'b0;
                        r_tail_ptr <= ptr_inc(r_tail_ptr);
                    end
                end
                S_HEAD: begin
                    if (w_nxt_occ) begin
                        r_dead <= 1'b1;
                    end else begin
                        r_bitmap[cell_idx(r_nxt_x, r_nxt_y)] <= 1'b1;
                        r_head_ptr                 <= w_head_ptr_nxt;
                        r_ring_x[w_head_ptr_nxt]   <= r_nxt_x;
                        r_ring_y[w_head_ptr_nxt]   <= r_nxt_y;
                        r_head_x                   <= r_nxt_x;
                        r_head_y                   <= r_nxt_y;
                        if (w_hit) begin
                            if (r_len < C_LEN_MAX) r_len <= r_len + 1'b1;
                            if (r_score != '1)     r_score <= r_score + 1'b1;
                        end
                    end
                end
                S_FOOD: begin
                    if (w_cand_ok) begin
                        r_food_x <= XW'(w_cx);
                        r_food_y <= YW'(w_cy);
                    end
                end
                default: ;
            endcase
        end
    end

    assign query_body = r_qbody;
    assign query_food = r_qfood;
    assign head_x     = r_head_x;
    assign head_y     = r_head_y;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign length     = r_len;
    assign score      = r_score;
    assign dead       = r_dead;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snake_core_ring.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_core_ring
//  Purpose  : Scoreboard bench for snake_core_ring with a queue-based game
//             model. Honours SNAKE_WALL_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_core_ring;
    localparam int COLS = 80, ROWS = 60, BODY_MAX = 64, SCORE_W = 8;
    localparam int XW = $clog2(COLS), YW = $clog2(ROWS), LW = $clog2(BODY_MAX + 1);

    logic clk = 1'b0, reset = 1'b0, step = 1'b0, dir_valid = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic [15:0] rnd = 16'd0;
    logic [XW-1:0] query_x = '0;
    logic [YW-1:0] query_y = '0;
    logic query_body, query_food, dead, busy;
    logic [XW-1:0] head_x, food_x;
    logic [YW-1:0] head_y, food_y;
    logic [LW-1:0] length;
    logic [SCORE_W-1:0] score;

    always #5 clk = ~clk;

    snake_core_ring #(.COLS(COLS), .ROWS(ROWS), .BODY_MAX(BODY_MAX), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .reset(reset), .step(step), .dir_valid(dir_valid), .dir_in(dir_in),
        .rnd(rnd), .query_x(query_x), .query_y(query_y), .query_body(query_body),
        .query_food(query_food), .head_x(head_x), .head_y(head_y), .food_x(food_x),
        .food_y(food_y), .length(length), .score(score), .dead(dead), .busy(busy));

    typedef struct { int hx, hy, len, score, dead, fx, fy, lat; } exp_t;
    exp_t sb_q[$];
    int n_cmp = 0, n_err = 0;

    // Reference game state: body as a queue of cell numbers, tail first.
    int body[$];
    int m_hx, m_hy, m_len, m_score, m_dead, m_fx, m_fy, m_pdir, m_cdir;
    logic [15:0] cand[$], force_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    function automatic bit occupied(input int x, input int y);
        foreach (body[i]) if (body[i] == y * COLS + x) return 1'b1;
        return 1'b0;
    endfunction

    // First acceptable candidate; returns how many were tried.
    function automatic int pick_food(output int fx, output int fy);
        fx = 0; fy = 0;
        foreach (cand[i]) begin
            int cx, cy;
            cx = int'(cand[i][15:8]);
            cy = int'(cand[i][7:0]);
            if (cx < COLS && cy < ROWS && !occupied(cx, cy)) begin
                fx = cx; fy = cy;
                return i + 1;
            end
        end
        return -1;
    endfunction

    // Candidate list: forced if provided, else a few random values then a free cell.
    function automatic void gen_cands();
        int x, y, n;
        cand.delete();
        if (force_q.size() > 0) begin
            cand = force_q;
            force_q.delete();
            return;
        end
        n = int'($urandom_range(0, 3));
        repeat (n) cand.push_back(16'($urandom()));
        do begin
            if ($urandom_range(0, 1) == 1) begin
                x = int'((m_hx + int'($urandom_range(2, 5))) % COLS);
                y = m_hy;
            end else begin
                x = int'($urandom_range(0, COLS - 1));
                y = int'($urandom_range(0, ROWS - 1));
            end
        end while (occupied(x, y));
        cand.push_back({8'(x), 8'(y)});
    endfunction

    function automatic void fill(output exp_t e, input int lat);
        e.hx = m_hx; e.hy = m_hy; e.len = m_len; e.score = m_score;
        e.dead = m_dead; e.fx = m_fx; e.fy = m_fy; e.lat = lat;
    endfunction

    function automatic void model_reset(output exp_t e);
        int n;
        body.delete();
        m_hx = COLS / 2; m_hy = ROWS / 2;
        body.push_back(m_hy * COLS + m_hx);
        m_len = 1; m_score = 0; m_dead = 0; m_pdir = 0; m_cdir = 0;
        gen_cands();
        n = pick_food(m_fx, m_fy);
        fill(e, n);
    endfunction

    // kind 0: move runs through the FSM; kind 1: immediate wall death.
    function automatic void model_move(output exp_t e, output int kind);
        int nx, ny, n;
        bit hit, grow;
        kind = 0; n = 0;
        m_cdir = m_pdir;
        nx = m_hx + ((m_pdir == 0) ? 1 : (m_pdir == 2) ? -1 : 0);
        ny = m_hy + ((m_pdir == 1) ? 1 : (m_pdir == 3) ? -1 : 0);
`ifdef SNAKE_WALL_EN
        if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) begin
            m_dead = 1; kind = 1;
            fill(e, 0);
            return;
        end
`endif
        nx = (nx + COLS) % COLS;
        ny = (ny + ROWS) % ROWS;
        hit  = (nx == m_fx) && (ny == m_fy);
        grow = hit && (m_len < BODY_MAX);
        if (!grow) void'(body.pop_front());
        if (occupied(nx, ny)) begin
            m_dead = 1;
        end else begin
            body.push_back(ny * COLS + nx);
            m_hx = nx; m_hy = ny;
            if (grow) m_len++;
            if (hit) begin
                m_score = (m_score == (1 << SCORE_W) - 1) ? m_score : m_score + 1;
                gen_cands();
                n = pick_food(m_fx, m_fy);
            end
        end
        fill(e, (hit && m_dead == 0) ? 2 + n : 2);
    endfunction

    function automatic logic [15:0] cand_at(input int j);
        int k;
        k = (j < 0) ? 0 : j;
        if (k >= cand.size()) k = cand.size() - 1;
        return cand[k];
    endfunction

    task automatic timeout_stop(input string name);
        n_cmp++; n_err++;
        $display("FAIL %s: busy still 1 after 200 cycles, required 0", name);
        print_summary();
        $finish;
    endtask

    task automatic do_reset();
        exp_t e;
        int j;
        reset = 1'b1; step = 1'b0; dir_valid = 1'b0;
        query_x = XW'(COLS / 2); query_y = YW'(ROWS / 2);
        model_reset(e);
        rnd = cand_at(0);
        sb_q.push_back(e);
        @(posedge clk); @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_head_x", head_x, 40);
        chk("rst_head_y", head_y, 30);
        chk("rst_length", length, 1);
        chk("rst_score", score, 0);
        chk("rst_dead", dead, 0);
        chk("rst_qbody", query_body, 0);
        reset = 1'b0;
        j = 0;
        while (busy === 1'b1) begin
            if (j >= 200) timeout_stop("rst_food_timeout");
            rnd = cand_at(j);
            @(posedge clk); @(negedge clk);
            j++;
        end
        chk("rst_qbody_head", query_body, 1);
    endtask

    task automatic do_move(input bit st, input bit dv, input logic [1:0] d);
        exp_t e;
        int kind, j;
        bit acc, dok;
        kind = 0;
        acc = st && (m_dead == 0);
        dok = dv && !(m_len > 1 && int'(d) == (m_cdir ^ 2));
        if (acc) model_move(e, kind);
        if (dok) m_pdir = int'(d);
        step = st; dir_valid = dv; dir_in = d;
        if (cand.size() > 0) rnd = cand_at(0);
        if (acc && kind == 0) sb_q.push_back(e);
        @(posedge clk); @(negedge clk);
        step = 1'b0; dir_valid = 1'b0;
        if (!acc) begin
            chk("idle_busy", busy, 0);
            return;
        end
        if (kind == 1) begin
            chk("wall_dead", dead, 1);
            chk("wall_busy", busy, 0);
            chk("wall_head_x", head_x, m_hx);
            return;
        end
        j = 0;
        while (busy === 1'b1) begin
            if (j >= 200) timeout_stop("move_timeout");
            rnd = cand_at(j - 2);
            @(posedge clk); @(negedge clk);
            j++;
        end
    endtask

    task automatic qchk(input int x, input int y);
        bit in_rng;
        query_x = XW'(x); query_y = YW'(y);
        @(posedge clk); @(negedge clk);
        in_rng = (x < COLS) && (y < ROWS);
        chk("query_body", query_body, int'(in_rng && occupied(x, y)));
        chk("query_food", query_food, int'(in_rng && x == m_fx && y == m_fy));
    endtask

    // Monitor: every busy->idle transition completes one scoreboard entry.
    int  mon_cnt = 0;
    bit  mon_prev = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            mon_cnt++;
        end else if (mon_prev) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: completion with empty scoreboard, required none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("head_x", head_x, e.hx);
                chk("head_y", head_y, e.hy);
                chk("length", length, e.len);
                chk("score", score, e.score);
                chk("dead", dead, e.dead);
                chk("food_x", food_x, e.fx);
                chk("food_y", food_y, e.fy);
                chk("latency", mon_cnt, e.lat);
            end
            mon_cnt = 0;
        end
        mon_prev = (busy === 1'b1);
    end

    initial begin
        #500000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        print_summary();
        $finish;
    end

    initial begin
        int r, d;
        repeat (2) @(negedge clk);

        // Reset, first food and query port.
        force_q = {16'h0A05};
        do_reset();
        chk("init_food_x", food_x, 10);
        chk("init_food_y", food_y, 5);
        qchk(40, 30);
        qchk(80, 0);
        qchk(10, 5);

        // Run along row 30 to the right edge.
        repeat (39) do_move(1'b1, 1'b0, 2'd0);
        chk("edge_head_x", head_x, 79);
        chk("edge_head_y", head_y, 30);
        do_move(1'b1, 1'b0, 2'd0);
`ifdef SNAKE_WALL_EN
        chk("wall_stay_x", head_x, 79);
        chk("wall_dead_set", dead, 1);
        do_move(1'b1, 1'b0, 2'd0);
        chk("wall_ignored_x", head_x, 79);
`else
        chk("wrap_head_x", head_x, 0);
        chk("wrap_head_y", head_y, 30);
        chk("wrap_dead", dead, 0);
`endif

        // Eat, then four rejected candidates before (1,1).
        force_q = {16'h291E};
        do_reset();
        force_q = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0101};
        do_move(1'b1, 1'b0, 2'd0);
        chk("eat_length", length, 2);
        chk("eat_score", score, 1);
        chk("eat_food_x", food_x, 1);
        chk("eat_food_y", food_y, 1);

        // Grow to five, reversal rejected at length two, then bite own body.
        force_q = {16'h291E};
        do_reset();
        force_q = {16'h2A1E};
        do_move(1'b1, 1'b0, 2'd0);
        do_move(1'b0, 1'b1, 2'd2);
        force_q = {16'h2B1E};
        do_move(1'b1, 1'b0, 2'd0);
        chk("rev_head_x", head_x, 42);
        force_q = {16'h2C1E};
        do_move(1'b1, 1'b0, 2'd0);
        force_q = {16'h0A05};
        do_move(1'b1, 1'b0, 2'd0);
        chk("grow_length", length, 5);
        do_move(1'b0, 1'b1, 2'd1); do_move(1'b1, 1'b0, 2'd0);
        do_move(1'b0, 1'b1, 2'd2); do_move(1'b1, 1'b0, 2'd0);
        do_move(1'b0, 1'b1, 2'd3); do_move(1'b1, 1'b0, 2'd0);
        chk("bite_dead", dead, 1);
        chk("bite_score", score, 4);
        do_move(1'b1, 1'b0, 2'd0);
        chk("bite_head_x", head_x, 43);
        chk("bite_head_y", head_y, 31);

        // Randomised play against the model.
        force_q.delete();
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if (m_dead != 0) begin
                do_move(1'b1, 1'b0, 2'd0);
                do_reset();
                continue;
            end
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) begin
                if (m_fx != m_hx) d = (m_fx > m_hx) ? 0 : 2;
                else              d = (m_fy > m_hy) ? 1 : 3;
            end else begin
                d = int'($urandom_range(0, 3));
            end
            case (r)
                0:       qchk(int'($urandom_range(0, 127)), int'($urandom_range(0, 63)));
                1:       qchk(m_fx, m_fy);
                2, 3:    do_move(1'b0, 1'b1, 2'(d));
                4:       do_move(1'b1, 1'b1, 2'(d));
                default: do_move(1'b1, 1'b0, 2'd0);
            endcase
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        print_summary();
        $finish;
    end
endmodule
`default_nettype wire
